// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

    localparam int DEF_DW  = 8;
    localparam int DEF_TOW = 24;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for the UART arbiter.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = DEF_DW
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ-1:0]    req_ready;
    logic [DW-1:0]      tdr;
    logic               tdrwr;
    logic               tdre;

    modport master (
        output req_valid, req_data, req_lock, tdre,
        input  req_ready, tdr, tdrwr
    );

    modport slave (
        input  req_valid, req_data, req_lock, tdre,
        output req_ready, tdr, tdrwr
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin winner selection with an optional sticky lock holder.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            lock_hold,
    input  logic [IW-1:0]   lock_id,
    output logic [IW-1:0]   winner,
    output logic            any_valid
);

    int          idx;
    logic [IW-1:0] cand;
    logic        found;

    always_comb begin
        winner    = ptr;
        any_valid = |req;
        found     = 1'b0;
        idx       = 0;
        cand      = '0;
        if (lock_hold && req[lock_id]) begin
            winner = lock_id;
            found  = 1'b1;
        end
        // explicit wrap so non-power-of-two NREQ never indexes past NREQ-1
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = IW'(idx);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NREQ byte requesters.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = DEF_DW,
    parameter int TOW  = DEF_TOW
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_tx_arbiter_if.slave         bus,
    input  logic [TOW-1:0]           timeout_cycles,
    input  logic                     err_clr,
    output logic                     timeout_err,
    output logic [clog2(NREQ)-1:0]   grant_id,
    output logic                     busy
);

    localparam int IW = clog2(NREQ);

    state_t          state, state_n;
    logic [IW-1:0]   ptr, ptr_n;
    logic            lock_hold, lock_n;
    logic [TOW-1:0]  wd, wd_n;
    logic            wd_en, wd_en_n;
    logic [DW-1:0]   tdr_q, tdr_n;
    logic            tdrwr_q, tdrwr_n;
    logic [NREQ-1:0] ready_q, ready_n;
    logic [IW-1:0]   grant_n;
    logic            err_n, busy_n, expire;
    logic [IW-1:0]   win;
    logic            any_valid;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .lock_hold (lock_hold),
        .lock_id   (grant_id),
        .winner    (win),
        .any_valid (any_valid)
    );

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        lock_n  = lock_hold;
        wd_n    = wd;
        wd_en_n = wd_en;
        tdr_n   = tdr_q;
        tdrwr_n = 1'b0;
        ready_n = '0;
        grant_n = grant_id;
        expire  = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_valid) begin
                    tdr_n        = bus.req_data[int'(win)*DW +: DW];
                    tdrwr_n      = 1'b1;
                    ready_n[win] = 1'b1;
                    grant_n      = win;
                    lock_n       = bus.req_lock[win];
                    ptr_n        = (win == IW'(NREQ-1)) ? '0 : win + 1'b1;
                    state_n      = SEND;
                end
            end
            SEND: begin
                wd_n    = timeout_cycles;
                wd_en_n = |timeout_cycles;
                state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.tdre) begin
                    state_n = IDLE;
                end else if (wd_en) begin
                    // wd counts the WAIT_DONE cycles still tolerated
                    if (wd <= TOW'(1)) begin
                        expire  = 1'b1;
                        lock_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        wd_n = wd - 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        err_n  = expire | (timeout_err & ~err_clr);
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            lock_hold   <= 1'b0;
            wd          <= '0;
            wd_en       <= 1'b0;
            tdr_q       <= '0;
            tdrwr_q     <= 1'b0;
            ready_q     <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            lock_hold   <= lock_n;
            wd          <= wd_n;
            wd_en       <= wd_en_n;
            tdr_q       <= tdr_n;
            tdrwr_q     <= tdrwr_n;
            ready_q     <= ready_n;
            grant_id    <= grant_n;
            timeout_err <= err_n;
            busy        <= busy_n;
        end
    end

    assign bus.tdr       = tdr_q;
    assign bus.tdrwr     = tdrwr_q;
    assign bus.req_ready = ready_q;

endmodule
